// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: int+frac prescaler (frac part built only with BAUD_TICK_FRAC_EN) driving os/bit/mid strobes.
// Latency: all strobes registered; first os_tick DEF_DIV enabled cycles after reset or div_q cycles after resync.
// Backpressure: none; en=0 freezes all counters and suppresses every strobe.
module baud_tick_gen #(
  parameter int CNT_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_DIV  = 54,
  parameter int DEF_FRAC = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  OS_MID_PRE = OS_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_RST    = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN    = CNT_W'(2);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_int;
  logic [CNT_W-1:0] ld_int;
  logic [CNT_W-1:0] new_div;
  logic [CNT_W-1:0] reload;
  logic [OS_W-1:0]  os_cnt;
  logic             pend_vld;
  logic             wrap;
  logic             carry;

  // A divisor below 2 would leave os_tick stuck high.
  assign ld_int  = (div_int < DIV_MIN) ? DIV_MIN : div_int;
  assign new_div = div_load ? ld_int : (pend_vld ? pend_int : div_q);
  assign wrap    = en && (cnt == '0);
  assign reload  = carry ? new_div : new_div - 1'b1;

`ifdef BAUD_TICK_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] new_frac;
  logic [FRAC_W:0]   acc_sum;

  assign new_frac = div_load ? div_frac : (pend_vld ? pend_frac : frac_q);
  assign acc_sum  = {1'b0, acc} + {1'b0, new_frac};
  assign carry    = acc_sum[FRAC_W];

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      frac_q    <= FRAC_W'(DEF_FRAC);
      pend_frac <= '0;
      acc       <= '0;
    end else begin
      if (div_load) begin
        pend_frac <= div_frac;
      end
      if (resync) begin
        frac_q <= new_frac;
        acc    <= '0;
      end else if (!en || wrap) begin
        frac_q <= new_frac;
        if (wrap) begin
          acc <= acc_sum[FRAC_W-1:0];
        end
      end
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_q    <= DIV_RST;
      pend_int <= '0;
      pend_vld <= 1'b0;
      cnt      <= DIV_RST - 1'b1;
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
      if (div_load) begin
        pend_int <= ld_int;
      end
      if (resync) begin
        div_q    <= new_div;
        pend_vld <= 1'b0;
        os_cnt   <= '0;
        cnt      <= new_div - 1'b1;
      end else if (!en) begin
        // Frozen: a new divisor takes effect at once, the count itself holds.
        div_q    <= new_div;
        pend_vld <= 1'b0;
      end else if (wrap) begin
        div_q    <= new_div;
        pend_vld <= 1'b0;
        cnt      <= reload;
        os_tick  <= 1'b1;
        os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        bit_tick <= (os_cnt == OS_LAST);
        mid_tick <= (os_cnt == OS_MID_PRE);
      end else begin
        cnt <= cnt - 1'b1;
        if (div_load) begin
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen; expected tick cycles are queued as stimulus is driven and popped as strobes appear.
module tb_baud_tick_gen;

`ifdef BAUD_TICK_FRAC_EN
  localparam int FR = 4;
`else
  localparam int FR = 0;
`endif

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        resync;
  logic        os_tick;
  logic        bit_tick;
  logic        mid_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_t, os_n, kw, t0;
  int exp_os[$];
  int exp_bit[$];
  int exp_mid[$];

  baud_tick_gen dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (en),
    .div_int (div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .resync  (resync),
    .os_tick (os_tick),
    .bit_tick(bit_tick),
    .mid_tick(mid_tick)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_seen(input string tag, input int qsize);
    total++;
    assert (qsize > 0) else begin
      bad++;
      $error("FAIL %s unexpected strobe observed at cycle %0d expected none", tag, cyc);
    end
  endtask

  // Strobes are compared against the cycle number at which they were predicted.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (os_tick) begin
        chk_seen("os_tick", exp_os.size());
        if (exp_os.size() > 0) chk("os_tick cycle", cyc, exp_os.pop_front());
      end
      if (bit_tick) begin
        chk_seen("bit_tick", exp_bit.size());
        if (exp_bit.size() > 0) chk("bit_tick cycle", cyc, exp_bit.pop_front());
      end
      if (mid_tick) begin
        chk_seen("mid_tick", exp_mid.size());
        if (exp_mid.size() > 0) chk("mid_tick cycle", cyc, exp_mid.pop_front());
      end
    end
  end

  // Extra cycle contributed by the fractional part on the k-th wrap since acc was cleared.
  function automatic int cy(input int k);
    return ((k + 1) * FR) / 16 - (k * FR) / 16;
  endfunction

  task automatic tick_after(input int p);
    cur_t += p;
    os_n++;
    exp_os.push_back(cur_t);
    if (os_n % 16 == 0) exp_bit.push_back(cur_t);
    if (os_n % 16 == 8) exp_mid.push_back(cur_t);
  endtask

  task automatic default_run(input int base);
    cur_t = base;
    os_n  = 0;
    kw    = 0;
    tick_after(54);
    repeat (16) begin
      tick_after(54 + cy(kw));
      kw++;
    end
  endtask

  task automatic at(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic settle(input int t);
    at(t);
    #1;
  endtask

  task automatic load(input int d);
    div_int  = 16'(d);
    div_frac = '0;
    div_load = 1'b1;
    @(negedge sys_clk);
    div_load = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk_bit({tag, " os_tick"}, os_tick, 1'b0);
    chk_bit({tag, " bit_tick"}, bit_tick, 1'b0);
    chk_bit({tag, " mid_tick"}, mid_tick, 1'b0);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " os_tick missing"}, exp_os.size(), 0);
    chk({tag, " bit_tick missing"}, exp_bit.size(), 0);
    chk({tag, " mid_tick missing"}, exp_mid.size(), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; div_int = '0; div_frac = '0; div_load = 1'b0; resync = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk_zero("reset");

    // Default divisor straight out of reset.
    rst = 1'b0;
    default_run(cyc);
    settle(cur_t + 3);
    chk_empty("default");

    // Resync 20 cycles into a period.
    at(cur_t + 20);
    resync = 1'b1;
    t0 = cyc + 1;
    @(negedge sys_clk);
    resync = 1'b0;
    default_run(t0);
    settle(cur_t + 3);
    chk_empty("resync");

    // Mid-period load: current period finishes at the old divisor.
    at(cur_t + 20);
    load(10);
    tick_after(54 + cy(kw));
    kw++;
    repeat (20) tick_after(10);
    settle(cur_t);
    chk_empty("load10");

    // Second load overwrites the first; div_int=1 clamps to 2.
    t0 = cur_t;
    at(t0 + 2);
    load(7);
    load(1);
    tick_after(10);
    repeat (6) tick_after(2);
    settle(cur_t);
    chk_empty("clamp");

    // Freeze mid-period, load while frozen, resume the remaining count.
    load(30);
    tick_after(2);
    tick_after(30);
    settle(cur_t);
    t0 = cur_t;
    at(t0 + 10);
    en = 1'b0;
    at(t0 + 50);
    load(12);
    at(t0 + 110);
    en = 1'b1;
    tick_after(130);
    repeat (5) tick_after(12);
    settle(cur_t);
    chk_empty("freeze");

    // Reset while a strobe is high.
    chk_bit("pre-reset os_tick", os_tick, 1'b1);
    #1 rst = 1'b1;
    #1 chk_zero("async reset");
    repeat (3) begin
      @(negedge sys_clk);
      chk_zero("held reset");
    end
    rst = 1'b0;
    default_run(cyc);
    settle(cur_t + 3);
    chk_empty("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
